// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;

    typedef enum logic [1:0] {
        S_BOOT    = 2'd0,
        S_REQ     = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } fetch_state_t;

    localparam int          PC_STEP = 4;
    localparam logic [31:0] INS_NOP = 32'h0000_0013;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush clears valid, stall freezes, load captures,
// otherwise a bubble is inserted while the pc/instr payload is kept.
module ifid_reg #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             stall,
    input  logic             load,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [INS_W-1:0] instr_in,
    output logic [PC_W-1:0]  pc,
    output logic [INS_W-1:0] instr,
    output logic             valid
);

    // Flush beats stall; stall beats load; an idle cycle becomes a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= '0;
            instr <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (stall) begin
            valid <= valid;
        end else if (load) begin
            pc    <= pc_in;
            instr <= instr_in;
            valid <= 1'b1;
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem request/ready handshake, one-word
// hold buffer for hazard stalls, and squashing of fetches made stale by a
// redirect.
//
// state     | meaning
// S_BOOT    | one idle cycle after reset, no request
// S_REQ     | request at pc outstanding; words go to IF/ID
// S_HOLD    | word captured during stall, waiting to enter IF/ID
// S_DISCARD | stale request in flight; its word is dropped, then jump
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             PcSel,
    input  logic [31:0]      BrPC,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    input  logic             imem_ready,
    output logic [PC_W-1:0]  ifid_pc,
    output logic [INS_W-1:0] ifid_instr,
    output logic             ifid_valid,
    output logic             redirect_pending
);

    fetch_state_t     state, state_nxt;
    logic [PC_W-1:0]  pc, pc_nxt;
    logic [PC_W-1:0]  hold_pc, hold_pc_nxt;
    logic [INS_W-1:0] hold_instr, hold_instr_nxt;
    logic [PC_W-1:0]  pend_pc, pend_pc_nxt;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  pc_inc;
    logic             ifid_flush, ifid_load;
    logic [PC_W-1:0]  ifid_pc_in;
    logic [INS_W-1:0] ifid_instr_in;
    logic             unused_brpc;

    // Redirect targets are word aligned and confined to the PC address space.
    assign target      = {BrPC[PC_W-1:2], 2'b00};
    assign unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};
    assign pc_inc      = pc + PC_W'(PC_STEP);

    assign imem_addr        = pc;
    assign imem_req         = (state == S_REQ) || (state == S_DISCARD);
    assign redirect_pending = (state == S_DISCARD);

    // State, PC, hold buffer and pending target registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_BOOT;
            pc         <= RESET_PC;
            hold_pc    <= '0;
            hold_instr <= '0;
            pend_pc    <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            hold_pc    <= hold_pc_nxt;
            hold_instr <= hold_instr_nxt;
            pend_pc    <= pend_pc_nxt;
        end
    end

    // Next-state, PC update and IF/ID control.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        hold_pc_nxt    = hold_pc;
        hold_instr_nxt = hold_instr;
        pend_pc_nxt    = pend_pc;
        ifid_flush     = 1'b0;
        ifid_load      = 1'b0;
        ifid_pc_in     = pc;
        ifid_instr_in  = imem_rdata;

        unique case (state)
            S_BOOT: begin
                state_nxt = S_REQ;
            end
            S_REQ: begin
                if (PcSel) begin
                    ifid_flush = 1'b1;
                    if (imem_ready) begin
                        pc_nxt = target;
                    end else begin
                        pend_pc_nxt = target;
                        state_nxt   = S_DISCARD;
                    end
                end else if (imem_ready && !stall) begin
                    ifid_load = 1'b1;
                    pc_nxt    = pc_inc;
                end else if (imem_ready) begin
                    hold_pc_nxt    = pc;
                    hold_instr_nxt = imem_rdata;
                    pc_nxt         = pc_inc;
                    state_nxt      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (PcSel) begin
                    ifid_flush = 1'b1;
                    pc_nxt     = target;
                    state_nxt  = S_REQ;
                end else if (!stall) begin
                    ifid_load     = 1'b1;
                    ifid_pc_in    = hold_pc;
                    ifid_instr_in = hold_instr;
                    state_nxt     = S_REQ;
                end
            end
            S_DISCARD: begin
                if (PcSel) begin
                    ifid_flush  = 1'b1;
                    pend_pc_nxt = target;
                end
                if (imem_ready) begin
                    pc_nxt    = PcSel ? target : pend_pc;
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_BOOT;
            end
        endcase
    end

    ifid_reg #(
        .PC_W  (PC_W),
        .INS_W (INS_W)
    ) u_ifid (
        .clk      (clk),
        .reset    (reset),
        .flush    (ifid_flush),
        .stall    (stall),
        .load     (ifid_load),
        .pc_in    (ifid_pc_in),
        .instr_in (ifid_instr_in),
        .pc       (ifid_pc),
        .instr    (ifid_instr),
        .valid    (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a zero-logic instruction memory whose
// data is derived from the address.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        PcSel;
    logic [31:0] BrPC;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [8:0]  ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        redirect_pending;

    int n_vec = 0;
    int n_err = 0;

    fetch_stage #(.PC_W(9), .INS_W(32), .RESET_PC(9'h000)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .PcSel            (PcSel),
        .BrPC             (BrPC),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .imem_ready       (imem_ready),
        .ifid_pc          (ifid_pc),
        .ifid_instr       (ifid_instr),
        .ifid_valid       (ifid_valid),
        .redirect_pending (redirect_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [8:0] a);
        return 32'hA500_0000 | {23'b0, a};
    endfunction

    assign imem_rdata = word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic p, input logic [31:0] b, input logic r);
        stall      = s;
        PcSel      = p;
        BrPC       = b;
        imem_ready = r;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 32'h0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_pc",    {23'b0, ifid_pc}, 32'd0);
        chk("rst_instr", ifid_instr, 32'd0);
        chk("rst_addr",  {23'b0, imem_addr}, 32'd0);
        reset = 1'b0;

        // boot: one idle cycle, then zero-wait streaming
        #1;
        chk("boot_req", {31'b0, imem_req}, 32'd0);
        tick();
        chk("s1_req",   {31'b0, imem_req}, 32'd1);
        chk("s1_addr",  {23'b0, imem_addr}, 32'h000);
        chk("s1_valid", {31'b0, ifid_valid}, 32'd0);
        tick();
        chk("s2_addr",  {23'b0, imem_addr}, 32'h004);
        chk("s2_valid", {31'b0, ifid_valid}, 32'd1);
        chk("s2_pc",    {23'b0, ifid_pc}, 32'h000);
        chk("s2_instr", ifid_instr, word(9'h000));
        tick();
        chk("s3_addr",  {23'b0, imem_addr}, 32'h008);
        chk("s3_pc",    {23'b0, ifid_pc}, 32'h004);
        tick();
        tick();
        chk("s5_addr",  {23'b0, imem_addr}, 32'h010);
        chk("s5_pc",    {23'b0, ifid_pc}, 32'h00C);

        // zero-wait redirect: word at 0x010 dropped, target alignment
        drive(0, 1, 32'h0000_0103, 1);
        tick();
        chk("br_valid", {31'b0, ifid_valid}, 32'd0);
        chk("br_addr",  {23'b0, imem_addr}, 32'h100);
        drive(0, 0, 32'h0, 1);
        tick();
        chk("br_pc",    {23'b0, ifid_pc}, 32'h100);
        chk("br_instr", ifid_instr, word(9'h100));
        chk("br_v2",    {31'b0, ifid_valid}, 32'd1);
        chk("br_addr2", {23'b0, imem_addr}, 32'h104);

        // redirect during a 3-cycle wait, last target wins
        drive(0, 0, 32'h0, 0);
        tick();
        chk("w_bubble", {31'b0, ifid_valid}, 32'd0);
        chk("w_pc_kept", {23'b0, ifid_pc}, 32'h100);
        chk("w_addr",   {23'b0, imem_addr}, 32'h104);
        drive(0, 1, 32'h0000_0040, 0);
        tick();
        chk("d1_pend",  {31'b0, redirect_pending}, 32'd1);
        chk("d1_req",   {31'b0, imem_req}, 32'd1);
        chk("d1_addr",  {23'b0, imem_addr}, 32'h104);
        drive(0, 1, 32'h0000_0080, 0);
        tick();
        chk("d2_pend",  {31'b0, redirect_pending}, 32'd1);
        chk("d2_addr",  {23'b0, imem_addr}, 32'h104);
        drive(0, 0, 32'h0, 1);
        tick();
        chk("d3_pend",  {31'b0, redirect_pending}, 32'd0);
        chk("d3_addr",  {23'b0, imem_addr}, 32'h080);
        chk("d3_valid", {31'b0, ifid_valid}, 32'd0);
        chk("d3_pc",    {23'b0, ifid_pc}, 32'h100);
        tick();
        chk("d4_pc",    {23'b0, ifid_pc}, 32'h080);
        chk("d4_valid", {31'b0, ifid_valid}, 32'd1);

        // stall arriving with ready at pc=0x020
        drive(0, 1, 32'h0000_0020, 1);
        tick();
        chk("h0_addr",  {23'b0, imem_addr}, 32'h020);
        drive(1, 0, 32'h0, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("h_req",   {31'b0, imem_req}, 32'd0);
            chk("h_addr",  {23'b0, imem_addr}, 32'h024);
            chk("h_pc",    {23'b0, ifid_pc}, 32'h080);
            chk("h_valid", {31'b0, ifid_valid}, 32'd0);
        end
        drive(0, 0, 32'h0, 1);
        tick();
        chk("h5_pc",    {23'b0, ifid_pc}, 32'h020);
        chk("h5_instr", ifid_instr, word(9'h020));
        chk("h5_valid", {31'b0, ifid_valid}, 32'd1);
        chk("h5_addr",  {23'b0, imem_addr}, 32'h024);
        chk("h5_req",   {31'b0, imem_req}, 32'd1);
        tick();
        chk("h6_pc",    {23'b0, ifid_pc}, 32'h024);

        // PC wrap; upper BrPC bits ignored
        drive(0, 1, 32'hFFFF_FFFE, 1);
        tick();
        chk("wr_addr0", {23'b0, imem_addr}, 32'h1FC);
        drive(0, 0, 32'h0, 1);
        tick();
        chk("wr_pc",    {23'b0, ifid_pc}, 32'h1FC);
        chk("wr_addr",  {23'b0, imem_addr}, 32'h000);
        tick();
        chk("wr_addr2", {23'b0, imem_addr}, 32'h004);

        // async reset mid-wait
        drive(0, 0, 32'h0, 0);
        tick();
        chk("ar_req_pre", {31'b0, imem_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_req",   {31'b0, imem_req}, 32'd0);
        chk("ar_addr",  {23'b0, imem_addr}, 32'h000);
        chk("ar_instr", ifid_instr, 32'd0);
        chk("ar_pend",  {31'b0, redirect_pending}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 32'h0, 1);
        #1;
        chk("rb_req",   {31'b0, imem_req}, 32'd0);
        tick();
        chk("rb_req1",  {31'b0, imem_req}, 32'd1);
        chk("rb_addr1", {23'b0, imem_addr}, 32'h000);
        tick();
        chk("rb_valid", {31'b0, ifid_valid}, 32'd1);
        chk("rb_instr", ifid_instr, word(9'h000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the execute-side branch logic. It consumes the branch unit's PcSel/BrPC redirect and produces the IF/ID pipeline register (PC, instruction, valid).
- Owns the PC register and drives a variable-latency instruction-memory request/ready handshake.
- Holds one fetched word in a buffer during hazard stalls.
- Discards in-flight fetches made stale by a taken branch or jump.

Parameters:
- PC_W, 9, width of PC and instruction-memory byte address.
- INS_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit freeze of PC and IF/ID.
- PcSel  in  1  redirect request from branch unit (taken branch or jump).
- BrPC  in  32  redirect target; valid when PcSel=1.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch byte address.
- imem_rdata  in  INS_W  fetched instruction; valid when imem_req & imem_ready.
- imem_ready  in  1  memory completes the current request this cycle.
- ifid_pc  out  PC_W  PC of the instruction in IF/ID.
- ifid_instr  out  INS_W  instruction in IF/ID.
- ifid_valid  out  1  IF/ID holds a real instruction; 0 means bubble.
- redirect_pending  out  1  high while in S_DISCARD.

Behaviour:
- Reset (asynchronous) values:
  - state=S_BOOT, pc=RESET_PC.
  - ifid_pc=0, ifid_instr=0, ifid_valid=0.
  - hold buffer=0, pending target=0.
  - imem_req=0, redirect_pending=0.
- Reset asserted mid-request abandons that request; the memory must accept a dropped request.
- Handshake:
  - imem_addr=pc in every state; imem_req=1 in S_REQ and S_DISCARD.
  - While imem_req=1 and imem_ready=0, imem_addr and imem_req stay stable.
  - A transfer occurs on any cycle with imem_req & imem_ready. Best case is 1 word/cycle, with ready in the same cycle as the request.
- Target and PC arithmetic:
  - Target = {BrPC[PC_W-1:2], 2'b00}; BrPC upper bits are ignored.
  - pc+4 wraps modulo 2^PC_W.
- S_BOOT: imem_req=0 for exactly one cycle, then go to S_REQ. PcSel is ignored in this state.
- S_REQ, evaluated in this priority order:
  - (1) PcSel=1: ifid_valid<=0 (flush, overrides stall).
    - If imem_ready=1: drop the word, pc<=target, stay in S_REQ.
    - Otherwise: pending<=target, go to S_DISCARD.
  - (2) imem_ready=1 and stall=0: ifid<={pc, imem_rdata, 1}; pc<=pc+4.
  - (3) imem_ready=1 and stall=1: hold buffer<={pc, imem_rdata}; pc<=pc+4; IF/ID unchanged; go to S_HOLD.
  - (4) imem_ready=0 and stall=0: ifid_valid<=0 (bubble); ifid_pc and ifid_instr keep their values.
  - (5) imem_ready=0 and stall=1: IF/ID unchanged.
- S_HOLD: imem_req=0.
  - PcSel=1: drop the buffer, ifid_valid<=0, pc<=target, go to S_REQ.
  - Else stall=0: ifid<={buffer, 1}, go to S_REQ.
  - Else: hold all state.
- S_DISCARD: redirect_pending=1.
  - The outstanding request completes normally; its word is never written to IF/ID or the buffer.
  - ifid_valid stays 0 in this state.
  - A further PcSel overwrites pending (last target wins).
  - On imem_ready=1: pc<=pending (or the current-cycle target if PcSel=1), go to S_REQ.
- Stall alone never changes the PC except when a word is captured in (3). The IF/ID contents are frozen whenever stall=1 and no flush occurs.
- Simultaneous PcSel with stall: the flush wins, and the redirect is applied in the same cycle.

Decomposition:
- Shared package (riscv_pkg) holds:
  - enum fetch_state_t {S_BOOT, S_REQ, S_HOLD, S_DISCARD};
  - constants PC_STEP=4 and INS_NOP=32'h00000013.
- One natural sub-module: ifid_reg. It holds the pc/instr/valid register with stall-hold and flush-clear, flush taking priority.
- FSM, PC and hold buffer stay in fetch_stage.

Test Plan:
- Reset release, imem_ready tied 1, imem_rdata=addr-derived values:
  - imem_req=0 for one cycle, then addresses 0x000, 0x004, 0x008.
  - ifid_valid=1 from the second post-boot edge; ifid_pc trails imem_addr by one cycle.
- Zero-wait streaming, PcSel=1 with BrPC=0x0000_0103 at pc=0x010:
  - The word at 0x010 is discarded and ifid_valid=0 for that cycle.
  - Next imem_addr=0x100 (BrPC bits 1:0 cleared).
- Redirect during a 3-cycle wait, BrPC=0x040 then BrPC=0x080 one cycle later:
  - redirect_pending=1 until ready; the returned word never reaches IF/ID.
  - The next request goes to 0x080.
- stall=1 for 4 cycles arriving with ready at pc=0x020:
  - The word is buffered, imem_req=0, IF/ID is frozen.
  - When stall drops, ifid={0x020, word}, valid=1, and the next fetch is 0x024.
- PC wrap: pc=0x1FC with ready → next imem_addr=0x000.
- Async reset asserted mid-wait (req=1, ready=0):
  - All outputs go to reset values immediately, without a clock edge.
  - After release, boot repeats from RESET_PC.
